// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder block.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Byte address to word index shift for 32-bit words.
  localparam int unsigned ADDR_SHIFT = 2;

endpackage

// File: rtl/rr_arbiter.sv
// N-way request arbiter producing a one-hot grant.
// MEM_RESP_RR_EN: round-robin with a pointer; otherwise fixed priority (lowest index wins).
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

`ifdef MEM_RESP_RR_EN
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  int unsigned   idx;

  // Search starts at the pointer; pointer moves past the winner on advance.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    idx   = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(ptr_q) + off) % N;
      if (req[idx] && (grant == '0)) begin
        grant[idx] = 1'b1;
        if (advance) begin
          ptr_d = PW'((idx + 1) % N);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && (grant == '0)) begin
        grant[i] = 1'b1;
      end
    end
  end

  logic unused_rr;
  assign unused_rr = ^{clk, reset, advance};
`endif

endmodule

// File: rtl/mem_responder.sv
// Shared word-addressed RAM serving NCORES load/store requesters, one at a time, LAT-cycle latency.
// MEM_RESP_RR_EN selects round-robin arbitration (fixed priority when undefined).
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned NCORES = 2,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LAT    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCORES-1:0]    req_valid,
  input  logic [NCORES-1:0]    req_we,
  input  logic [NCORES*32-1:0] req_addr,
  input  logic [NCORES*32-1:0] req_wdata,
  output logic [NCORES-1:0]    req_ready,
  output logic [NCORES-1:0]    resp_valid,
  output logic [31:0]          resp_rdata,
  input  logic [NCORES-1:0]    resp_ready
);

  localparam int unsigned GW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [GW-1:0]       gidx_q, gidx_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [NCORES-1:0]   rvalid_q, rvalid_d;

  logic [31:0]         mem [0:(1 << ADDR_W) - 1];

  logic [NCORES-1:0]   grant;
  logic                accept;
  logic                commit;
  logic                handshake;
  logic [GW-1:0]       sel_idx;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [31:0]         sel_wdata;

  rr_arbiter #(.N(NCORES)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign req_ready  = (state_q == S_IDLE) ? grant : '0;
  assign accept     = |req_ready;
  assign commit     = (state_q == S_BUSY) && (cnt_q == '0);
  assign handshake  = |(rvalid_q & resp_ready);
  assign resp_valid = rvalid_q;
  assign resp_rdata = rdata_q;

  // Low address bits and bits above the word index are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^req_addr;

  always_comb begin
    sel_idx   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      if (grant[i]) begin
        sel_idx   = GW'(i);
        sel_we    = req_we[i];
        sel_addr  = req_addr[32*i + ADDR_SHIFT +: ADDR_W];
        sel_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  // BUSY counts down from LAT-1 and commits when it reaches zero, so every LAT
  // (including 1) goes through BUSY and resp_valid rises exactly LAT edges after accept.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gidx_d   = gidx_q;
    we_d     = we_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          gidx_d  = sel_idx;
          we_d    = sel_we;
          waddr_d = sel_addr;
          wdata_d = sel_wdata;
          cnt_d   = CNT_INIT;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d          = S_RESP;
          rvalid_d         = '0;
          rvalid_d[gidx_q] = 1'b1;
          rdata_d          = we_q ? '0 : mem[waddr_q];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (handshake) begin
          state_d  = S_IDLE;
          rvalid_d = '0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        rvalid_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      gidx_q   <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gidx_q   <= gidx_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && we_q) begin
      mem[waddr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with LAT = 1, 2, 3 share inputs;
// only the instance under test is out of reset at any time.
module tb_mem_responder;

  logic        clk;
  logic [2:0]  rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  resp_ready;
  logic [1:0]  req_ready_o  [3];
  logic [1:0]  resp_valid_o [3];
  logic [31:0] resp_rdata_o [3];

  int tests = 0;
  int fails = 0;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mem_responder #(.NCORES(2), .ADDR_W(10), .LAT(k + 1)) u_dut (
      .clk        (clk),
      .reset      (rst[k]),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready_o[k]),
      .resp_valid (resp_valid_o[k]),
      .resp_rdata (resp_rdata_o[k]),
      .resp_ready (resp_ready)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          d;
    int          c;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic focus(input int d);
    rst        = 3'b111;
    req_valid  = '0;
    resp_ready = '0;
    repeat (2) @(negedge clk);
    rst = ~(3'b001 << d);
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic issue(input int d, input int c, input bit we, input logic [31:0] a,
                       input logic [31:0] wd);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    req_valid[c]         = 1'b1;
    req_we[c]            = we;
    req_addr[32*c +: 32]  = a;
    req_wdata[32*c +: 32] = wd;
    while (!acc && tries < 20) begin
      #1;
      acc = req_ready_o[d][c];
      @(posedge clk);
      tries++;
      @(negedge clk);
    end
    req_valid[c] = 1'b0;
    check($sformatf("accept d%0d c%0d", d, c), {31'b0, acc}, 32'd1);
  endtask

  task automatic wait_resp(input int d, input int c, output int lat);
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      if (resp_valid_o[d][c]) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_req(input int d, input int c, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat);
    issue(d, c, we, a, wd);
    wait_resp(d, c, lat);
    rd = resp_rdata_o[d];
    resp_ready[c] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[c] = 1'b0;
    check($sformatf("resp_drop d%0d", d), {30'b0, resp_valid_o[d]}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    int          cur;
    int          got [4];
    int          n;
    bit          oh_ok;
    bit          seen;
    int          acc_cyc [2];

    vecs[0]  = '{1, 0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 2};
    vecs[1]  = '{1, 0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 2};
    vecs[2]  = '{1, 1, 1'b1, 32'h0000_0013, 32'hCAFE_F00D, 32'h0000_0000, 2};
    vecs[3]  = '{1, 1, 1'b0, 32'h0000_1010, 32'h0,         32'hCAFE_F00D, 2};
    vecs[4]  = '{1, 0, 1'b1, 32'h0000_0FFC, 32'h1234_5678, 32'h0000_0000, 2};
    vecs[5]  = '{1, 0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h1234_5678, 2};
    vecs[6]  = '{1, 1, 1'b0, 32'h0000_0011, 32'h0,         32'hCAFE_F00D, 2};
    vecs[7]  = '{0, 0, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 32'h0000_0000, 1};
    vecs[8]  = '{0, 1, 1'b0, 32'h0000_0040, 32'h0,         32'hA5A5_A5A5, 1};
    vecs[9]  = '{2, 1, 1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0000_0000, 3};
    vecs[10] = '{2, 0, 1'b0, 32'h0000_0020, 32'h0,         32'h1111_1111, 3};

    rst        = 3'b111;
    req_valid  = '0;
    req_we     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = '0;
    @(negedge clk);

    // Reset state
    focus(1);
    #1;
    check("reset req_ready", {30'b0, req_ready_o[1]}, 32'd0);
    check("reset resp_valid", {30'b0, resp_valid_o[1]}, 32'd0);
    check("reset resp_rdata", resp_rdata_o[1], 32'd0);
    @(negedge clk);

    // Table of single transactions
    cur = 1;
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].d != cur) begin
        focus(vecs[i].d);
        cur = vecs[i].d;
      end
      do_req(vecs[i].d, vecs[i].c, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
    end

    // Response backpressure with a competing request pending
    focus(1);
    issue(1, 1, 1'b0, 32'h0000_0010, 32'h0);
    wait_resp(1, 1, lat);
    check("bp latency", lat, 32'd2);
    req_we[0]         = 1'b0;
    req_addr[31:0]    = 32'h0000_0044;
    req_valid[0]      = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp%0d resp_valid", k), {30'b0, resp_valid_o[1]}, 32'd2);
      check($sformatf("bp%0d resp_rdata", k), resp_rdata_o[1], 32'hCAFE_F00D);
      check($sformatf("bp%0d req_ready", k), {30'b0, req_ready_o[1]}, 32'd0);
      @(negedge clk);
    end
    req_valid[0]  = 1'b0;
    resp_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[1] = 1'b0;
    check("bp release", {30'b0, resp_valid_o[1]}, 32'd0);

    // Arbitration with both cores continuously requesting
    focus(1);
    req_we             = 2'b00;
    req_addr[31:0]     = 32'h0000_0100;
    req_addr[63:32]    = 32'h0000_0200;
    req_valid          = 2'b11;
    resp_ready         = 2'b11;
    n     = 0;
    oh_ok = 1'b1;
    for (int k = 0; k < 4; k++) got[k] = -1;
    for (int cyc = 0; cyc < 80 && n < 4; cyc++) begin
      #1;
      if (!$onehot0(req_ready_o[1])) oh_ok = 1'b0;
      if (req_ready_o[1] != 2'b00) begin
        got[n] = req_ready_o[1][1] ? 1 : 0;
        n++;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    repeat (8) @(negedge clk);
    resp_ready = 2'b00;
    check("arb grant count", n, 32'd4);
    check("arb onehot", {31'b0, oh_ok}, 32'd1);
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_RESP_RR_EN
      check($sformatf("arb grant%0d", k), got[k], k % 2);
`else
      check($sformatf("arb grant%0d", k), got[k], 32'd0);
`endif
    end

    // Reset one cycle after a store is accepted (LAT=3)
    focus(2);
    issue(2, 0, 1'b1, 32'h0000_0020, 32'h0000_0055);
    @(posedge clk);
    @(negedge clk);
    rst[2] = 1'b1;
    seen   = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid_o[2] != 2'b00) seen = 1'b1;
    end
    rst[2] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid_o[2] != 2'b00) seen = 1'b1;
    end
    check("rst no response", {31'b0, seen}, 32'd0);
    do_req(2, 0, 1'b0, 32'h0000_0020, 32'h0, rd, lat);
    check("rst store discarded", rd, 32'h1111_1111);
    check("rst load latency", lat, 32'd3);

    // LAT=1 accept spacing
    focus(0);
    req_we[0]      = 1'b0;
    req_addr[31:0] = 32'h0000_0040;
    req_valid[0]   = 1'b1;
    resp_ready[0]  = 1'b1;
    n = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    for (int cyc = 0; cyc < 40 && n < 2; cyc++) begin
      #1;
      if (req_ready_o[0][0]) begin
        acc_cyc[n] = cyc;
        n++;
      end
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    resp_ready[0] = 1'b0;
    check("lat1 accept count", n, 32'd2);
    check($sformatf("lat1 spacing>=2 (gap %0d)", acc_cyc[1] - acc_cyc[0]),
          {31'b0, (acc_cyc[1] - acc_cyc[0]) >= 2}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
